th_mn_array: RTL

//  Clocked emulation of CH independent generalised weighted threshold gates (THmn with hysteresis),
//  for FPGA prototyping of the NCL datapath. Adds per-channel state, a completion detector and an

---
 rtl/th_pkg.sv | 27 ++
 rtl/th_mn_cell.sv | 66 ++++++
 rtl/th_mn_array.sv | 87 ++++++++
 3 files changed

// File: rtl/th_pkg.sv
// Shared types and sizing helpers for the threshold-gate array.
package th_pkg;

  typedef enum logic {TH_NUL, TH_SET} th_state_e;

  localparam string TH_ENC_FP = "FP";
  localparam string TH_ENC_TP = "TP";

  function automatic int th_sum_w(int in_num, int wgt_w);
    return $clog2(in_num * ((1 << wgt_w) - 1) + 1);
  endfunction

  function automatic int th_wsum(
    logic [511:0] wgt,
    int           in_num,
    int           wgt_w
  );
    int s;
    logic [511:0] m;
    s = 0;
    m = (512'd1 << wgt_w) - 512'd1;
    for (int i = 0; i < in_num; i++)
      s += int'((wgt >> (i * wgt_w)) & m);
    return s;
  endfunction

endpackage

// File: rtl/th_mn_cell.sv
// One THmn gate channel: optional input register,
// weighted sum and NUL/SET hysteresis state.
module th_mn_cell
  import th_pkg::*;
#(
  parameter string ENC    = TH_ENC_FP,
  parameter int    IN_NUM = 4,
  parameter int    WGT_W  = 2,
  parameter logic [IN_NUM*WGT_W-1:0] WGT =
    {IN_NUM{WGT_W'(1)}},
  parameter int    THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [IN_NUM-1:0] in_i,
  output logic              out_o
);

  localparam int SW = th_sum_w(IN_NUM, WGT_W);

  logic [IN_NUM-1:0] gin;
  logic [SW-1:0]     sum;
  th_state_e         state_q, state_d;

  if (ENC == TH_ENC_TP) begin : g_tp
    logic [IN_NUM-1:0] in_q;
    always_ff @(posedge clk) begin
      if (rst)       in_q <= '0;
      else if (en_i) in_q <= in_i;
    end
    assign gin = in_q;
  end else begin : g_fp
    assign gin = in_i;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < IN_NUM; i++)
      if (gin[i])
        sum = sum + SW'(WGT[i*WGT_W +: WGT_W]);
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      unique case (state_q)
        TH_NUL:
          if (sum >= SW'(THRESH))
            state_d = TH_SET;
        TH_SET:
          if (gin == '0)
            state_d = TH_NUL;
        default: state_d = TH_NUL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= TH_NUL;
    else     state_q <= state_d;
  end

  assign out_o = (state_q == TH_SET);

endmodule

// File: rtl/th_mn_array.sv
// CH-wide THmn gate array with completion detect.
// Optional stall watchdog enabled by TH_WDOG_EN.
module th_mn_array
  import th_pkg::*;
#(
  parameter string ENC    = TH_ENC_FP,
  parameter int    IN_NUM = 4,
  parameter int    CH     = 8,
  parameter int    WGT_W  = 2,
  parameter logic [IN_NUM*WGT_W-1:0] WGT =
    {IN_NUM{WGT_W'(1)}},
  parameter int    THRESH = 2,
  parameter int    WDOG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CH*IN_NUM-1:0] in,
  output logic [CH-1:0]        out,
  output logic                 all_set,
  output logic                 all_null,
  output logic                 stall
);

  localparam int WSUM =
    th_wsum(512'(WGT), IN_NUM, WGT_W);

  if (THRESH < 1 || THRESH > WSUM) begin : g_bad_thresh
    $error("th_mn_array: THRESH %0d outside 1..%0d",
           THRESH, WSUM);
  end

  if (WDOG_W < 1) begin : g_bad_wdog
    $error("th_mn_array: WDOG_W must be >= 1");
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    th_mn_cell #(
      .ENC   (ENC),
      .IN_NUM(IN_NUM),
      .WGT_W (WGT_W),
      .WGT   (WGT),
      .THRESH(THRESH)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .in_i (in[c*IN_NUM +: IN_NUM]),
      .out_o(out[c])
    );
  end

  assign all_set  = &out;
  assign all_null = ~|out;

`ifdef TH_WDOG_EN
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]     prev_q;
  logic              mixed;

  assign mixed = !all_set && !all_null;

  // prev_q tracks out so a wavefront step restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (out != prev_q)
      cnt_d = '0;
    else if (en && mixed && !(&cnt_q))
      cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= out;
    end
  end

  assign stall = &cnt_q;
`else
  assign stall = 1'b0;
`endif

endmodule
